// File: rtl/cpu_bus_master_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_master_if
// Description : Request-side and 68030-style bus-side signals of the
//               single-beat bus cycle initiator.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_bus_master_if;
  // Agent request side
  logic        REQ;
  logic        REQ_RW;
  logic [23:0] REQ_ADDR;
  logic [1:0]  REQ_SIZ;
  logic [7:0]  REQ_WDATA;
  logic        BUSY;
  logic        ACK;
  logic        ERR;
  logic [7:0]  RDATA;
  // CPU bus side
  logic [23:0] A;
  logic [1:0]  SIZ;
  logic        AS20;
  logic        DS20;
  logic        RW20;
  logic [7:0]  D_OUT;
  logic        D_OE;
  logic [7:0]  D_IN;
  logic        STERM;
  logic [1:0]  DSACK;
  logic        BERR;

  modport master (
    input  REQ, REQ_RW, REQ_ADDR, REQ_SIZ, REQ_WDATA, D_IN, STERM, DSACK, BERR,
    output BUSY, ACK, ERR, RDATA, A, SIZ, AS20, DS20, RW20, D_OUT, D_OE
  );

  modport slave (
    output REQ, REQ_RW, REQ_ADDR, REQ_SIZ, REQ_WDATA, D_IN, STERM, DSACK, BERR,
    input  BUSY, ACK, ERR, RDATA, A, SIZ, AS20, DS20, RW20, D_OUT, D_OE
  );
endinterface
`default_nettype wire

// File: rtl/cpu_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_master
// Description : 68030-style bus cycle initiator. Turns a single-beat agent
//               request into an AS20/DS20/RW20/SIZ/A cycle terminated by
//               STERM, synchronized DSACK, BERR or an internal timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_bus_master #(
  parameter int TIMEOUT = 255
) (
  input  logic              CLKCPU,
  input  logic              RESET,
  cpu_bus_master_if.master  bus
);

  localparam logic [7:0] c_timeout = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_STRB = 3'd2,
    S_END  = 3'd3,
    S_REC  = 3'd4
  } state_t;

  state_t      r_state,  w_state_nxt;
  logic [23:0] r_a,      w_a_nxt;
  logic [1:0]  r_siz,    w_siz_nxt;
  logic        r_rw20,   w_rw20_nxt;
  logic        r_as20,   w_as20_nxt;
  logic        r_ds20,   w_ds20_nxt;
  logic [7:0]  r_d_out,  w_d_out_nxt;
  logic        r_d_oe,   w_d_oe_nxt;
  logic        r_busy,   w_busy_nxt;
  logic        r_ack,    w_ack_nxt;
  logic        r_err,    w_err_nxt;
  logic [7:0]  r_rdata,  w_rdata_nxt;
  logic [7:0]  r_cnt,    w_cnt_nxt;
  logic [1:0]  r_dsack_s1, r_dsack_s2;
  logic        w_term, w_fault;

  // DSACK is asynchronous: two-flop synchronizer, parked at idle between cycles
  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      r_dsack_s1 <= 2'b11;
      r_dsack_s2 <= 2'b11;
    end else if (r_state == S_IDLE) begin
      r_dsack_s1 <= 2'b11;
      r_dsack_s2 <= 2'b11;
    end else begin
      r_dsack_s1 <= bus.DSACK;
      r_dsack_s2 <= r_dsack_s1;
    end
  end

  // State and registered bus outputs; reset releases every strobe at once
  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_a     <= 24'd0;
      r_siz   <= 2'd0;
      r_rw20  <= 1'b1;
      r_as20  <= 1'b1;
      r_ds20  <= 1'b1;
      r_d_out <= 8'd0;
      r_d_oe  <= 1'b0;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 8'd0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_siz   <= w_siz_nxt;
      r_rw20  <= w_rw20_nxt;
      r_as20  <= w_as20_nxt;
      r_ds20  <= w_ds20_nxt;
      r_d_out <= w_d_out_nxt;
      r_d_oe  <= w_d_oe_nxt;
      r_busy  <= w_busy_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_rdata <= w_rdata_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and next-output decode; termination sources in priority order
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_siz_nxt   = r_siz;
    w_rw20_nxt  = r_rw20;
    w_as20_nxt  = r_as20;
    w_ds20_nxt  = r_ds20;
    w_d_out_nxt = r_d_out;
    w_d_oe_nxt  = r_d_oe;
    w_busy_nxt  = r_busy;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = r_err;
    w_rdata_nxt = r_rdata;
    w_cnt_nxt   = r_cnt;
    w_term      = 1'b0;
    w_fault     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.REQ) begin
          w_state_nxt = S_ADDR;
          w_a_nxt     = bus.REQ_ADDR;
          w_siz_nxt   = bus.REQ_SIZ;
          w_rw20_nxt  = bus.REQ_RW;
          w_d_out_nxt = bus.REQ_WDATA;
          w_d_oe_nxt  = ~bus.REQ_RW;
          w_busy_nxt  = 1'b1;
        end
      end
      S_ADDR: begin
        // Address setup done; reads get DS20 together with AS20
        w_state_nxt = S_STRB;
        w_as20_nxt  = 1'b0;
        w_ds20_nxt  = ~r_rw20;
        w_cnt_nxt   = 8'd0;
      end
      S_STRB: begin
        // For writes this is where DS20 falls, one cycle behind AS20
        w_ds20_nxt = 1'b0;
        if (!bus.BERR) begin
          w_term  = 1'b1;
          w_fault = 1'b1;
        end else if (!bus.STERM && !r_ds20) begin
          w_term = 1'b1;
        end else if (r_dsack_s2 != 2'b11) begin
          w_term = 1'b1;
        end else if (r_cnt == c_timeout) begin
          w_term  = 1'b1;
          w_fault = 1'b1;
        end else if (r_cnt != 8'hFF) begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
        if (w_term) begin
          w_state_nxt = S_END;
          w_as20_nxt  = 1'b1;
          w_ds20_nxt  = 1'b1;
          w_d_oe_nxt  = 1'b0;
          w_rw20_nxt  = 1'b1;
          w_ack_nxt   = 1'b1;
          w_err_nxt   = w_fault;
          if (r_rw20 && !w_fault) begin
            w_rdata_nxt = bus.D_IN;
          end
        end
      end
      S_END: begin
        w_state_nxt = S_REC;
      end
      S_REC: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.A     = r_a;
  assign bus.SIZ   = r_siz;
  assign bus.RW20  = r_rw20;
  assign bus.AS20  = r_as20;
  assign bus.DS20  = r_ds20;
  assign bus.D_OUT = r_d_out;
  assign bus.D_OE  = r_d_oe;
  assign bus.BUSY  = r_busy;
  assign bus.ACK   = r_ack;
  assign bus.ERR   = r_err;
  assign bus.RDATA = r_rdata;

endmodule
`default_nettype wire
